// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with double-buffered display data,
// BCD/hex decode, decimal points, leading-zero blanking and an anti-ghost blank gap.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_CYC   = 2,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     dig_sel,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0]          SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [N_DIGITS-1:0] DIG_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

    function automatic logic [6:0] decode_nib(input logic [3:0] nib, input logic hex);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = hex ? 7'h77 : 7'h00;
            4'hB: s = hex ? 7'h7C : 7'h00;
            4'hC: s = hex ? 7'h39 : 7'h00;
            4'hD: s = hex ? 7'h5E : 7'h00;
            4'hE: s = hex ? 7'h79 : 7'h00;
            default: s = hex ? 7'h71 : 7'h00;
        endcase
        return s;
    endfunction

    logic [4*N_DIGITS-1:0] shd_value, act_value;
    logic [N_DIGITS-1:0]   shd_dp, act_dp;
    logic                  shd_hex, act_hex;
    logic                  shd_blz, act_blz;
    logic                  pending;

    logic [DIV_W-1:0]      div_p0;
    logic [IDX_W-1:0]      idx_p0;
    logic                  div_wrap, idx_last, frame_wrap;

    logic [7:0]            seg_p1;
    logic [N_DIGITS-1:0]   dig_sel_p1;
    logic                  frame_done_p1;

    assign div_wrap   = (div_p0 == DIV_W'(CLK_DIV - 1));
    assign idx_last   = (idx_p0 == IDX_W'(N_DIGITS - 1));
    assign frame_wrap = div_wrap & idx_last;

    // ---- stage p0: dwell/index counters and display buffers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            div_p0    <= '0;
            idx_p0    <= '0;
            pending   <= 1'b0;
            shd_value <= '0;
            shd_dp    <= '0;
            shd_hex   <= 1'b0;
            shd_blz   <= 1'b0;
            act_value <= '0;
            act_dp    <= '0;
            act_hex   <= 1'b0;
            act_blz   <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_p0 <= '0;
                idx_p0 <= idx_last ? '0 : idx_p0 + 1'b1;
            end else begin
                div_p0 <= div_p0 + 1'b1;
            end

            if (load) begin
                shd_value <= value;
                shd_dp    <= dp;
                shd_hex   <= hex_mode;
                shd_blz   <= blank_lz;
            end

            // Commit reads the old shadow even if a load lands in the same cycle.
            if (frame_wrap && pending) begin
                act_value <= shd_value;
                act_dp    <= shd_dp;
                act_hex   <= shd_hex;
                act_blz   <= shd_blz;
            end

            if (load)
                pending <= 1'b1;
            else if (frame_wrap)
                pending <= 1'b0;
        end
    end

    logic [N_DIGITS-1:0] lz_blank;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic [7:0]          seg_raw;
    logic                in_blank;

    // A digit is blanked only while every digit from the top down to it is zero.
    always_comb begin
        zero_run = act_blz;
        lz_blank = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run & (act_value[4*i +: 4] == 4'd0);
            lz_blank[i] = zero_run;
        end
    end

    assign cur_nib  = act_value[{idx_p0, 2'b00} +: 4];
    assign seg_raw  = {act_dp[idx_p0], lz_blank[idx_p0] ? 7'h00 : decode_nib(cur_nib, act_hex)};
    assign in_blank = (div_p0 < DIV_W'(BLANK_CYC));

    // ---- stage p1: registered pin drivers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p1        <= SEG_OFF;
            dig_sel_p1    <= DIG_OFF;
            frame_done_p1 <= 1'b0;
        end else begin
            seg_p1        <= (in_blank ? 8'h00 : seg_raw) ^ SEG_OFF;
            dig_sel_p1    <= (in_blank ? '0 : (DIG_ONE << idx_p0)) ^ DIG_OFF;
            frame_done_p1 <= frame_wrap;
        end
    end

    assign seg        = seg_p1;
    assign dig_sel    = dig_sel_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, 4-cycle dwell, 1 blank cycle; an active-high
// instance carries the table-driven frames and an active-low instance the reset case.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst, rst2, load, hex_mode, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg, seg2;
    logic [3:0]  dig_sel, dig2;
    logic        frame_done, fd2;

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done));

    seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)) dut_n (
        .clk(clk), .rst(rst2), .load(load), .value(value), .dp(dp), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .seg(seg2), .dig_sel(dig2), .frame_done(fd2));

    typedef struct {
        logic       which;
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        hex;
        logic        blz;
        logic [31:0] exp;   // {digit3, digit2, digit1, digit0} segment bytes
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   total  = 0;
    int   passed = 0;

    exp_t       me;
    logic [3:0] m_dig;
    logic [7:0] m_seg;
    logic       m_fd;
    int         scan_n = 0;

    // Each cycle with a queued expectation, compare the selected instance's pins.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me    = sb.pop_front();
            m_dig = me.which ? dig2 : dig_sel;
            m_seg = me.which ? seg2 : seg;
            m_fd  = me.which ? fd2  : frame_done;
            total++;
            if ({m_dig, m_seg, m_fd} === {me.dig, me.seg, me.fd})
                passed++;
            else
                $display("FAIL scan%0d(dut%0d) got dig_sel=%b seg=%h frame_done=%b, want dig_sel=%b seg=%h frame_done=%b",
                         scan_n, me.which, m_dig, m_seg, m_fd, me.dig, me.seg, me.fd);
            scan_n++;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s got %h want %h", name, act, want);
    endtask

    // One full frame as seen on the pins: per digit one blank cycle then three lit cycles.
    task automatic push_frame(input logic [31:0] s, input logic which);
        exp_t       e;
        logic [7:0] so;
        logic [3:0] dof;
        so  = which ? 8'hFF : 8'h00;
        dof = which ? 4'hF : 4'h0;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                e.which = which;
                e.fd    = (d == 3 && c == 3);
                if (c == 0) begin
                    e.dig = dof;
                    e.seg = so;
                end else begin
                    e.dig = 4'(1 << d) ^ dof;
                    e.seg = s[8*d +: 8] ^ so;
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_fd(input logic which);
        bit seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if ((which ? fd2 : frame_done) === 1'b1) seen = 1;
        end
        if (!seen) begin
            total++;
            $display("FAIL frame_done_timeout dut%0d got no pulse in 64 cycles, want one every 16", which);
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] d, input logic h, input logic b);
        value    = v;
        dp       = d;
        hex_mode = h;
        blank_lz = b;
        load     = 1'b1;
    endtask

    logic [31:0] prev;

    initial begin
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, 1'b0, 32'h06DB4F66};
        vecs[1] = '{16'h00A5, 4'b0000, 1'b0, 1'b1, 32'h0000006D};
        vecs[2] = '{16'h00A5, 4'b0000, 1'b1, 1'b1, 32'h0000776D};
        vecs[3] = '{16'h0000, 4'b1000, 1'b0, 1'b1, 32'h8000003F};
        vecs[4] = '{16'hFEDC, 4'b0000, 1'b1, 1'b0, 32'h71795E39};
        vecs[5] = '{16'h0089, 4'b0001, 1'b0, 1'b0, 32'h3F3F7FEF};
        vecs[6] = '{16'h0100, 4'b0000, 1'b0, 1'b1, 32'h00063F3F};
        vecs[7] = '{16'h00B0, 4'b0000, 1'b0, 1'b0, 32'h3F3F003F};

        rst = 1'b1; rst2 = 1'b1; load = 1'b0;
        value = '0; dp = '0; hex_mode = 1'b0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg",       16'(seg),        16'h0000);
        chk("rst_dig_sel",   16'(dig_sel),    16'h0000);
        chk("rst_frame",     16'(frame_done), 16'h0000);
        chk("rst_seg_n",     16'(seg2),       16'h00FF);
        chk("rst_dig_sel_n", 16'(dig2),       16'h000F);
        rst = 1'b0; rst2 = 1'b0;
        @(posedge clk);
        push_frame(32'h3F3F3F3F, 1'b0);
        prev = 32'h3F3F3F3F;

        // Each new value is loaded mid-frame; that frame must still show the old one.
        for (int k = 0; k < 8; k++) begin
            wait_fd(1'b0);
            @(posedge clk);
            push_frame(prev, 1'b0);
            repeat (5) @(negedge clk);
            drive(vecs[k].value, vecs[k].dp, vecs[k].hex, vecs[k].blz);
            @(negedge clk);
            load = 1'b0;
            prev = vecs[k].exp;
        end

        // Second load lands exactly in the commit cycle.
        wait_fd(1'b0);
        @(posedge clk);
        push_frame(prev, 1'b0);
        repeat (5) @(negedge clk);
        drive(16'h1111, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        drive(16'h2222, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 load = 1'b0;
        wait_fd(1'b0);
        @(posedge clk);
        push_frame(32'h06060606, 1'b0);
        wait_fd(1'b0);
        @(posedge clk);
        push_frame(32'h5B5B5B5B, 1'b0);
        wait_fd(1'b0);

        // Active-low instance: a pending load followed by reset mid-frame must be dropped.
        repeat (3) @(negedge clk);
        drive(16'h9999, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        rst2 = 1'b1;
        @(negedge clk);
        chk("midrst_seg_n",     16'(seg2), 16'h00FF);
        chk("midrst_dig_sel_n", 16'(dig2), 16'h000F);
        chk("midrst_frame_n",   16'(fd2),  16'h0000);
        rst2 = 1'b0;
        @(posedge clk);
        push_frame(32'h3F3F3F3F, 1'b1);
        wait_fd(1'b1);
        @(posedge clk);
        push_frame(32'h3F3F3F3F, 1'b1);

        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain got %0d pending expectations, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
